// File: rtl/dmux_router_pkg.sv
// Shared constants for the dmux_router stream router: destination encodings
// and the holding-register state type.
package dmux_router_pkg;

    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/dmux_router_dmux16.sv
// 1-bit DMux steering cell and a WIDTH-bit bank of them.
// A sel of 0 routes the input to out_a, a sel of 1 routes it to out_b; the unused side reads 0.
module dmux (
    input  logic in_bit,
    input  logic sel,
    output logic out_a,
    output logic out_b
);
    assign out_a = in_bit & ~sel;
    assign out_b = in_bit & sel;
endmodule

module dmux16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in_word,
    input  logic             sel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        dmux u_cell (
            .in_bit (in_word[gi]),
            .sel    (sel),
            .out_a  (out_a[gi]),
            .out_b  (out_b[gi])
        );
    end
endmodule

// File: rtl/dmux_router_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/dmux_router.sv
// One-entry registered router steering a word stream to sink A or B, by tag or
// by strict alternation, with per-sink saturating delivery counters.
module dmux_router
    import dmux_router_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_DEST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             MODE,
    output logic [WIDTH-1:0] A_DATA,
    output logic [WIDTH-1:0] B_DATA,
    output logic             A_VALID,
    output logic             B_VALID,
    input  logic             A_READY,
    input  logic             B_READY,
    input  logic             CLR_CNT,
    output logic [CNT_W-1:0] CNT_A,
    output logic [CNT_W-1:0] CNT_B,
    output logic             NEXT_DEST
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_dest_q, hold_dest_d;
    logic             next_dest_q, next_dest_d;

    logic             held_valid;
    logic [WIDTH-1:0] steer_data;
    logic             a_fire, b_fire, fire, acc;

    // Presented word is masked during reset so no VALID escapes before the flops clear.
    assign held_valid = (state_q == ST_FULL) && !RESET;
    assign steer_data = held_valid ? hold_data_q : '0;

    dmux u_valid_dmux (
        .in_bit (held_valid),
        .sel    (hold_dest_q),
        .out_a  (A_VALID),
        .out_b  (B_VALID)
    );

    dmux16 #(.WIDTH(WIDTH)) u_data_dmux (
        .in_word (steer_data),
        .sel     (hold_dest_q),
        .out_a   (A_DATA),
        .out_b   (B_DATA)
    );

    assign a_fire   = A_VALID & A_READY;
    assign b_fire   = B_VALID & B_READY;
    assign fire     = a_fire | b_fire;
    // Pass-through: a draining word frees the register for a new one in the same cycle.
    assign IN_READY = !RESET && ((state_q == ST_EMPTY) || fire);
    assign acc      = IN_VALID & IN_READY;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_dest_d = hold_dest_q;
        next_dest_d = next_dest_q;
        if (acc) begin
            state_d     = ST_FULL;
            hold_data_d = IN_DATA;
            hold_dest_d = MODE ? next_dest_q : IN_DEST;
            if (MODE) begin
                next_dest_d = ~next_dest_q;
            end
        end else if (fire) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_dest_q <= DEST_A;
            next_dest_q <= DEST_A;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_dest_q <= hold_dest_d;
            next_dest_q <= next_dest_d;
        end
    end

    assign NEXT_DEST = next_dest_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk  (CLK),
        .srst (RESET),
        .inc  (a_fire),
        .clr  (CLR_CNT),
        .cnt  (CNT_A)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk  (CLK),
        .srst (RESET),
        .inc  (b_fire),
        .clr  (CLR_CNT),
        .cnt  (CNT_B)
    );
endmodule

// File: doc/dmux_router.md
# dmux_router

Registered stream router that steers a WIDTH-bit word stream from one source to one of two sinks (A or B) using valid/ready handshakes. It adds flow control, buffering and scheduling around the 1-bit `DMux` steering primitive. The destination is either tagged per word or chosen by strict alternation. It sits between a producer (e.g. the CPU memory-write path) and two consumers sharing that producer, and provides per-sink delivery counters for debug.

## Interface
Parameters:
- `WIDTH`, 16, data word width
- `CNT_W`, 8, width of each delivery counter

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `IN_DATA`  in  WIDTH  source word
- `IN_DEST`  in  1  destination tag: 0 selects A, 1 selects B; used only when MODE=0
- `IN_VALID`  in  1  source word valid
- `IN_READY`  out  1  router can accept a word this cycle
- `MODE`  in  1  0 routes by tag, 1 routes by alternation (A, B, A, ...)
- `A_DATA`, `B_DATA`  out  WIDTH  held word on the selected sink, 0 on the other
- `A_VALID`, `B_VALID`  out  1  word valid toward sink A / B
- `A_READY`, `B_READY`  in  1  sink A / B accepts
- `CLR_CNT`  in  1  synchronous clear of both counters
- `CNT_A`, `CNT_B`  out  CNT_W  words delivered to A / B, saturating
- `NEXT_DEST`  out  1  alternation pointer: destination of the next word accepted in MODE=1

## Operation
- One-entry holding register: `hold_data`, `hold_dest`, plus state EMPTY/FULL.
- Input accept condition `acc` = IN_VALID & IN_READY.
- Output fire condition `fire` = (A_VALID & A_READY) | (B_VALID & B_READY).
- IN_READY = !RESET & (EMPTY | fire). Pass-through is supported: a word can load in the same cycle the held word drains.
- Destination is latched at acceptance: MODE ? NEXT_DEST : IN_DEST.
- MODE and IN_DEST are ignored at all other times. A MODE change never redirects a held word.
- NEXT_DEST toggles on every acc while MODE=1 and holds while MODE=0.
- In FULL, A_VALID = !hold_dest and B_VALID = hold_dest. Never both high.
- A_DATA = hold_data when A_VALID, else 0. B_DATA follows the same rule for B.
- Both VALIDs are 0 in EMPTY.
- State transitions:
  - EMPTY, acc → FULL.
  - FULL, fire & !acc → EMPTY.
  - FULL, fire & acc → FULL, holding the new word.
  - FULL, !fire → FULL. The held word is stable; the source is back-pressured.
- Counters:
  - CNT_A increments on A fire; CNT_B increments on B fire.
  - Each saturates at 2^CNT_W−1.
  - CLR_CNT has priority: the counter reads 0 after the edge and that cycle's increment is dropped.
- Reset (RESET high at the edge):
  - state EMPTY, NEXT_DEST=0, CNT_A=CNT_B=0, hold_data=0.
  - While RESET is high, IN_READY=0 and all VALIDs are 0.
  - Reset mid-transfer discards the held word; it is not counted.

## Timing
- Latency: a word accepted at edge N is presented (VALID high) during cycle N+1.
- Throughput: one word per cycle when the selected sink holds READY high.
- IN_READY has a combinational path from A_READY/B_READY. Downstream sinks must not derive READY from IN_VALID.
- VALID never drops without fire. DATA is stable while VALID=1 and READY=0.
- Counters and NEXT_DEST update on the same edge as the fire/accept that causes them.

## Structure
- Shared package / header: `DEST_A`=1'b0, `DEST_B`=1'b1, `ST_EMPTY`, `ST_FULL` localparams.
- Sub-module `DMux16` (WIDTH-bit bank of `DMux` cells) steers `hold_data` onto A_DATA/B_DATA by `hold_dest`. VALID steering reuses a single `DMux`.
- Counters are a small saturating-counter sub-module `sat_counter` (CNT_W, inc, clr), instantiated twice.

## Test plan
- Tag routing: MODE=0, both sinks READY, send 0x1111/dest0, 0x2222/dest1, 0x3333/dest0 back-to-back → A gets 0x1111 and 0x3333, B gets 0x2222. One word per cycle. CNT_A=2, CNT_B=1.
- Alternation: MODE=1, IN_DEST forced 1, send 4 words → order A, B, A, B. NEXT_DEST returns to 0. Switch to MODE=0 mid-stream → pointer freezes.
- Back-pressure: A_READY=0 for 5 cycles with word 0xBEEF held for A → A_VALID high and A_DATA=0xBEEF stable, IN_READY=0, B_VALID=0, B_DATA=0. Release → delivered once, CNT_A+1.
- Saturation/clear: CNT_W=8, deliver 260 words to B → CNT_B=255. Assert CLR_CNT coincident with a B delivery → CNT_B=0.
- Reset mid-operation: RESET while FULL with 0x5A5A for B → next cycle all VALIDs 0, IN_READY 0 during reset, counters 0, NEXT_DEST 0. 0x5A5A is never delivered.
